// File: rtl/ps2_packet_rx.sv
// PS/2 device-to-host receiver: glitch-filtered clock, 11-bit frame checks,
// and assembly of PKT_BYTES accepted bytes into one packet.
module ps2_packet_rx #(
  parameter int PKT_BYTES      = 3,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int FILTER_LEN     = 4,
  parameter int SYNC_CHECK     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  output logic [8*PKT_BYTES-1:0] packet,
  output logic                   packet_valid,
  output logic [7:0]             byte_data,
  output logic                   byte_valid,
  output logic                   err_parity,
  output logic                   err_frame,
  output logic                   err_timeout,
  output logic                   busy
);

  localparam int IW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [IW-1:0] LAST = IW'(PKT_BYTES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);

  logic                   r_clk_s1, r_clk_s2;
  logic                   r_dat_s1, r_dat_s2;
  logic                   r_filt, r_filt_q;
  logic [FW-1:0]          r_fcnt;
  logic [3:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_par;
  logic [IW-1:0]          r_idx;
  logic [7:0]             r_slot [PKT_BYTES];
  logic [TW-1:0]          r_to;
  logic                   w_fall;
  logic                   w_busy;
  logic [8*PKT_BYTES-1:0] w_pkt;

  assign w_fall = r_filt_q & ~r_filt;
  assign w_busy = (r_bit_cnt != 4'd0) || (r_idx != '0);
  assign busy   = w_busy;

  // Earlier slots go to the MSBs; the byte completing the packet is the LSB.
  always_comb begin
    w_pkt = '0;
    for (int i = 0; i < PKT_BYTES - 1; i++)
      w_pkt[8*(PKT_BYTES-1-i) +: 8] = r_slot[i];
    w_pkt[7:0] = r_shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_s1     <= 1'b1;
      r_clk_s2     <= 1'b1;
      r_dat_s1     <= 1'b1;
      r_dat_s2     <= 1'b1;
      r_filt       <= 1'b1;
      r_filt_q     <= 1'b1;
      r_fcnt       <= '0;
      r_bit_cnt    <= 4'd0;
      r_shift      <= 8'd0;
      r_par        <= 1'b0;
      r_idx        <= '0;
      r_to         <= '0;
      for (int i = 0; i < PKT_BYTES; i++)
        r_slot[i] <= 8'd0;
      packet       <= '0;
      packet_valid <= 1'b0;
      byte_data    <= 8'd0;
      byte_valid   <= 1'b0;
      err_parity   <= 1'b0;
      err_frame    <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      byte_valid   <= 1'b0;
      err_parity   <= 1'b0;
      err_frame    <= 1'b0;
      err_timeout  <= 1'b0;
      r_clk_s1     <= ps2_clk;
      r_clk_s2     <= r_clk_s1;
      r_dat_s1     <= ps2_data;
      r_dat_s2     <= r_dat_s1;
      r_filt_q     <= r_filt;
      if (r_clk_s2 != r_filt) begin
        if (r_fcnt == FMAX) begin
          r_filt <= r_clk_s2;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + FW'(1);
        end
      end else begin
        r_fcnt <= '0;
      end
      if (w_fall) begin
        r_to <= '0;
        unique case (1'b1)
          (r_bit_cnt == 4'd0): begin
            if (r_dat_s2) err_frame <= 1'b1;
            else          r_bit_cnt <= 4'd1;
          end
          (r_bit_cnt inside {[4'd1:4'd8]}): begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
          (r_bit_cnt == 4'd9): begin
            r_par     <= r_dat_s2;
            r_bit_cnt <= 4'd10;
          end
          default: begin
            r_bit_cnt <= 4'd0;
            if (!r_dat_s2) begin
              err_frame <= 1'b1;
              r_idx     <= '0;
            end else if (^{r_shift, r_par} == 1'b0) begin
              err_parity <= 1'b1;
              r_idx      <= '0;
            end else if (r_idx == '0 && SYNC_CHECK == 1 && !r_shift[3]) begin
              err_frame <= 1'b1;
            end else begin
              byte_data  <= r_shift;
              byte_valid <= 1'b1;
              if (r_idx == LAST) begin
                packet       <= w_pkt;
                packet_valid <= 1'b1;
                r_idx        <= '0;
              end else begin
                r_slot[r_idx] <= r_shift;
                r_idx         <= r_idx + IW'(1);
              end
            end
          end
        endcase
      end else if (!w_busy) begin
        r_to <= '0;
      end else if (r_to == TMAX) begin
        r_bit_cnt   <= 4'd0;
        r_idx       <= '0;
        err_timeout <= 1'b1;
        r_to        <= '0;
      end else begin
        r_to <= r_to + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_packet_rx.sv
// Bench for ps2_packet_rx: 3-byte and 4-byte instances share the PS/2 lines
// and are compared against a frame-level packet model.
module tb_ps2_packet_rx;

  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2c = 1'b1;
  logic        ps2d = 1'b1;
  logic [23:0] p3;
  logic [31:0] p4;
  logic        pv3, bv3, ep3, ef3, et3, bz3;
  logic        pv4, bv4, ep4, ef4, et4, bz4;
  logic [7:0]  bd3, bd4;

  int checks = 0;
  int fails  = 0;

  int          g_b[2], g_p[2], g_par[2], g_fr[2], g_to[2];
  logic [31:0] g_pkt[2];
  logic [7:0]  g_lb[2];
  int          e_b[2], e_p[2], e_par[2], e_fr[2], e_to[2];
  logic [31:0] e_pkt[2];
  logic [7:0]  e_lb[2];
  int          m_idx[2];
  logic [7:0]  m_buf[2][4];

  always #5 clk = ~clk;

  ps2_packet_rx #(.PKT_BYTES(3), .TIMEOUT_CYCLES(TO), .FILTER_LEN(4), .SYNC_CHECK(1)) u3 (
    .clk(clk), .reset(rst), .ps2_clk(ps2c), .ps2_data(ps2d),
    .packet(p3), .packet_valid(pv3), .byte_data(bd3), .byte_valid(bv3),
    .err_parity(ep3), .err_frame(ef3), .err_timeout(et3), .busy(bz3));

  ps2_packet_rx #(.PKT_BYTES(4), .TIMEOUT_CYCLES(TO), .FILTER_LEN(4), .SYNC_CHECK(1)) u4 (
    .clk(clk), .reset(rst), .ps2_clk(ps2c), .ps2_data(ps2d),
    .packet(p4), .packet_valid(pv4), .byte_data(bd4), .byte_valid(bv4),
    .err_parity(ep4), .err_frame(ef4), .err_timeout(et4), .busy(bz4));

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        g_b[k] = 0; g_p[k] = 0; g_par[k] = 0; g_fr[k] = 0; g_to[k] = 0;
        g_pkt[k] = '0; g_lb[k] = '0;
      end
    end else begin
      if (bv3) begin g_b[0]++; g_lb[0] = bd3; end
      if (pv3) begin g_p[0]++; g_pkt[0] = {8'h00, p3}; end
      if (ep3) g_par[0]++;
      if (ef3) g_fr[0]++;
      if (et3) g_to[0]++;
      if (bv4) begin g_b[1]++; g_lb[1] = bd4; end
      if (pv4) begin g_p[1]++; g_pkt[1] = p4; end
      if (ep4) g_par[1]++;
      if (ef4) g_fr[1]++;
      if (et4) g_to[1]++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ps2c = 1'b1; ps2d = 1'b1;
    cyc(5);
    rst = 1'b0;
    cyc(5);
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0;
      e_b[k] = 0; e_p[k] = 0; e_par[k] = 0; e_fr[k] = 0; e_to[k] = 0;
      e_pkt[k] = '0; e_lb[k] = '0;
    end
  endtask

  // Frame-level reference: what the receiver should report for one frame.
  task automatic model_frame(input logic [7:0] d, input bit bp, input bit bs);
    logic [31:0] p;
    int pk;
    for (int k = 0; k < 2; k++) begin
      pk = (k == 0) ? 3 : 4;
      if (bs) begin
        e_fr[k]++; m_idx[k] = 0;
      end else if (bp) begin
        e_par[k]++; m_idx[k] = 0;
      end else if (m_idx[k] == 0 && d[3] == 1'b0) begin
        e_fr[k]++;
      end else begin
        e_b[k]++; e_lb[k] = d;
        m_buf[k][m_idx[k]] = d;
        m_idx[k]++;
        if (m_idx[k] == pk) begin
          p = 0;
          for (int i = 0; i < pk; i++) p = (p << 8) | 32'(m_buf[k][i]);
          e_pkt[k] = p; e_p[k]++; m_idx[k] = 0;
        end
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bp, input bit bs);
    logic [10:0] f;
    int h;
    h = $urandom_range(10, 18);
    f = {~bs, (~^d) ^ bp, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2d = f[i];
      cyc(h);
      ps2c = 1'b0;
      cyc(h);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    cyc(30);
    model_frame(d, bp, bs);
  endtask

  task automatic send_bad_start();
    ps2d = 1'b1;
    cyc(12);
    ps2c = 1'b0;
    cyc(12);
    ps2c = 1'b1;
    cyc(30);
    e_fr[0]++; e_fr[1]++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    @(negedge clk);
    checks++;
    if ({p3, pv3, bd3, bv3, ep3, ef3, et3, bz3} !== '0) begin
      fails++;
      $display("FAIL reset_u3 got=%h exp=0", {p3, pv3, bd3, bv3, ep3, ef3, et3, bz3});
    end
    checks++;
    if ({p4, pv4, bd4, bv4, ep4, ef4, et4, bz4} !== '0) begin
      fails++;
      $display("FAIL reset_u4 got=%h exp=0", {p4, pv4, bd4, bv4, ep4, ef4, et4, bz4});
    end
    do_reset();
  endtask

  task automatic test_good();
    do_reset();
    send_frame(8'h08, 0, 0);
    send_frame(8'h10, 0, 0);
    send_frame(8'hF0, 0, 0);
    checks++;
    if (p3 !== 24'h0810F0) begin
      fails++; $display("FAIL good_pkt got=%h exp=0810f0", p3);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (g_b[k] !== 3 || g_p[k] !== e_p[k]) begin
        fails++;
        $display("FAIL good_cnt%0d got=%0d/%0d exp=3/%0d", k, g_b[k], g_p[k], e_p[k]);
      end
      checks++;
      if (g_par[k] + g_fr[k] + g_to[k] !== 0) begin
        fails++; $display("FAIL good_err%0d got=%0d exp=0", k, g_par[k] + g_fr[k] + g_to[k]);
      end
    end
    checks++;
    if (bz4 !== 1'b1 || bz3 !== 1'b0) begin
      fails++; $display("FAIL good_busy got=%b%b exp=01", bz3, bz4);
    end
  endtask

  task automatic test_parity();
    do_reset();
    send_frame(8'h09, 0, 0);
    send_frame(8'h22, 1, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (g_par[k] !== 1 || g_p[k] !== 0 || g_fr[k] !== 0) begin
        fails++;
        $display("FAIL parity_err%0d got=%0d/%0d/%0d exp=1/0/0", k, g_par[k], g_p[k], g_fr[k]);
      end
    end
    send_frame(8'h09, 0, 0);
    send_frame(8'h01, 0, 0);
    send_frame(8'h02, 0, 0);
    checks++;
    if (p3 !== 24'h090102 || g_p[0] !== 1) begin
      fails++; $display("FAIL parity_pkt got=%h/%0d exp=090102/1", p3, g_p[0]);
    end
  endtask

  task automatic test_align();
    do_reset();
    send_frame(8'h00, 0, 0);
    send_frame(8'h08, 0, 0);
    send_frame(8'h05, 0, 0);
    send_frame(8'h06, 0, 0);
    checks++;
    if (g_fr[0] !== 1 || g_fr[1] !== 1) begin
      fails++; $display("FAIL align_err got=%0d/%0d exp=1/1", g_fr[0], g_fr[1]);
    end
    checks++;
    if (p3 !== 24'h080506 || g_p[0] !== 1) begin
      fails++; $display("FAIL align_pkt got=%h/%0d exp=080506/1", p3, g_p[0]);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_frame(8'h08, 0, 0);
    checks++;
    if (bz3 !== 1'b1 || bz4 !== 1'b1) begin
      fails++; $display("FAIL to_busy_pre got=%b%b exp=11", bz3, bz4);
    end
    cyc(TO + 500);
    for (int k = 0; k < 2; k++)
      if (m_idx[k] != 0) begin e_to[k]++; m_idx[k] = 0; end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (g_to[k] !== e_to[k]) begin
        fails++; $display("FAIL to_count%0d got=%0d exp=%0d", k, g_to[k], e_to[k]);
      end
    end
    checks++;
    if (bz3 !== 1'b0 || bz4 !== 1'b0) begin
      fails++; $display("FAIL to_busy_post got=%b%b exp=00", bz3, bz4);
    end
    send_frame(8'h18, 0, 0);
    send_frame(8'h01, 0, 0);
    send_frame(8'hFF, 0, 0);
    checks++;
    if (p3 !== 24'h1801FF) begin
      fails++; $display("FAIL to_pkt got=%h exp=1801ff", p3);
    end
  endtask

  task automatic test_glitch_stop();
    do_reset();
    ps2d = 1'b0;
    cyc(5);
    ps2c = 1'b0; cyc(2); ps2c = 1'b1;
    cyc(20);
    ps2c = 1'b0; cyc(3); ps2c = 1'b1;
    cyc(20);
    ps2d = 1'b1;
    cyc(20);
    checks++;
    if (bz3 !== 1'b0 || bz4 !== 1'b0 || g_fr[0] !== 0) begin
      fails++; $display("FAIL glitch got=%b%b/%0d exp=00/0", bz3, bz4, g_fr[0]);
    end
    send_frame(8'h08, 0, 0);
    send_frame(8'h55, 0, 1);
    send_bad_start();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (g_fr[k] !== e_fr[k] || g_b[k] !== 1 || g_par[k] !== 0) begin
        fails++;
        $display("FAIL stop_err%0d got=%0d/%0d/%0d exp=%0d/1/0", k, g_fr[k], g_b[k], g_par[k], e_fr[k]);
      end
    end
    checks++;
    if (bz3 !== 1'b0 || bz4 !== 1'b0) begin
      fails++; $display("FAIL stop_busy got=%b%b exp=00", bz3, bz4);
    end
  endtask

  task automatic test_wheel();
    logic [7:0] b;
    do_reset();
    send_frame(8'h08, 0, 0);
    send_frame(8'h01, 0, 0);
    send_frame(8'h02, 0, 0);
    send_frame(8'hFF, 0, 0);
    checks++;
    if (p4 !== 32'h080102FF || g_p[1] !== 1) begin
      fails++; $display("FAIL wheel_pkt got=%h/%0d exp=080102ff/1", p4, g_p[1]);
    end
    send_frame(8'h08, 0, 0);
    ps2d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(12); ps2c = 1'b0; cyc(12); ps2c = 1'b1;
      ps2d = i[0];
    end
    rst = 1'b1;
    cyc(2);
    @(negedge clk);
    checks++;
    if ({p4, pv4, bd4, bv4, ep4, ef4, et4, bz4} !== '0) begin
      fails++; $display("FAIL mid_reset got=%h exp=0", {p4, pv4, bd4, bv4, ep4, ef4, et4, bz4});
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      if (i == 0) b[3] = 1'b1;
      send_frame(b, 0, 0);
    end
    checks++;
    if (p4 !== e_pkt[1] || g_p[1] !== 1) begin
      fails++; $display("FAIL wheel_after_reset got=%h/%0d exp=%h/1", p4, g_p[1], e_pkt[1]);
    end
    checks++;
    if (g_fr[1] + g_par[1] + g_to[1] !== 0) begin
      fails++; $display("FAIL wheel_err got=%0d exp=0", g_fr[1] + g_par[1] + g_to[1]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) send_bad_start();
      send_frame(8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (g_b[k] !== e_b[k] || g_p[k] !== e_p[k]) begin
        fails++;
        $display("FAIL rnd_cnt%0d got=%0d/%0d exp=%0d/%0d", k, g_b[k], g_p[k], e_b[k], e_p[k]);
      end
      checks++;
      if (g_par[k] !== e_par[k] || g_fr[k] !== e_fr[k] || g_to[k] !== 0) begin
        fails++;
        $display("FAIL rnd_err%0d got=%0d/%0d/%0d exp=%0d/%0d/0", k, g_par[k], g_fr[k], g_to[k], e_par[k], e_fr[k]);
      end
      checks++;
      if (g_pkt[k] !== e_pkt[k] || g_lb[k] !== e_lb[k]) begin
        fails++;
        $display("FAIL rnd_data%0d got=%h/%h exp=%h/%h", k, g_pkt[k], g_lb[k], e_pkt[k], e_lb[k]);
      end
    end
    checks++;
    if (bz3 !== (m_idx[0] != 0) || bz4 !== (m_idx[1] != 0)) begin
      fails++; $display("FAIL rnd_busy got=%b%b exp=%b%b", bz3, bz4, m_idx[0] != 0, m_idx[1] != 0);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_parity();
    test_align();
    test_timeout();
    test_glitch_stop();
    test_wheel();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
